// File: rtl/phys_freelist_pkg.sv
// Shared sizing constants for the R10K physical register free list.
// INITIAL_AVAIL_MASK is also used by retire's checkpoint register.
package phys_freelist_pkg;

  localparam int N_DEF              = 3;
  localparam int PHYS_REG_SZ_R10K   = 64;
  localparam int ARCH_REG_SZ        = 32;
  localparam int PHYS_TAG           = $clog2(PHYS_REG_SZ_R10K);

  // Architectural registers start out mapped to PR0..ARCH_REG_SZ-1, so only the upper PRs are free.
  localparam logic [PHYS_REG_SZ_R10K-1:0] INITIAL_AVAIL_MASK =
    {PHYS_REG_SZ_R10K{1'b1}} << ARCH_REG_SZ;

endpackage

// File: rtl/phys_freelist_psel.sv
// Picks the N lowest set bits of a vector, returned as one-hots, encoded tags and a found flag.
// Each stage is a priority encoder over what earlier stages left behind.
module freelist_psel #(
  parameter int N         = 3,
  parameter int PHYS_REGS = 64
) (
  input  logic [PHYS_REGS-1:0]                      vec,
  output logic [N-1:0][PHYS_REGS-1:0]               onehots,
  output logic [N-1:0][$clog2(PHYS_REGS)-1:0]       tags,
  output logic [N-1:0]                              found
);

  localparam int TW = $clog2(PHYS_REGS);

  logic [N:0][PHYS_REGS-1:0] remaining;

  always_comb begin
    remaining    = '0;
    onehots      = '0;
    tags         = '0;
    found        = '0;
    remaining[0] = vec;
    for (int k = 0; k < N; k++) begin
      // Scanning high to low leaves the lowest set bit as the final winner.
      for (int i = PHYS_REGS - 1; i >= 0; i--) begin
        if (remaining[k][i]) begin
          onehots[k] = PHYS_REGS'(1) << i;
          tags[k]    = TW'(i);
          found[k]   = 1'b1;
        end
      end
      remaining[k+1] = remaining[k] & ~onehots[k];
    end
  end

endmodule

// File: rtl/phys_freelist.sv
// R10K physical register free list: grants in-order destination tags to rename,
// reclaims retired Told registers, and reloads the committed mask on mispredict.
module phys_freelist
  import phys_freelist_pkg::*;
#(
  parameter int N          = N_DEF,
  parameter int PHYS_REGS  = PHYS_REG_SZ_R10K,
  parameter int ARCH_COUNT = ARCH_REG_SZ,
  localparam int CW        = $clog2(PHYS_REGS + 1),
  localparam int TW        = $clog2(PHYS_REGS)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N-1:0]         alloc_req,
  output logic [N-1:0]         alloc_grant,
  output logic [N*TW-1:0]      alloc_tags,
  input  logic [PHYS_REGS-1:0] free_mask,
  input  logic                 restore_en,
  input  logic [PHYS_REGS-1:0] restore_mask,
  output logic [CW-1:0]        free_count,
  output logic [PHYS_REGS-1:0] avail_dbg
);

  localparam logic [PHYS_REGS-1:0] INIT_MASK = {PHYS_REGS{1'b1}} << ARCH_COUNT;
  localparam logic [PHYS_REGS-1:0] PR0_MASK  = PHYS_REGS'(1);

  logic [PHYS_REGS-1:0]          avail;
  logic [PHYS_REGS-1:0]          avail_next;
  logic [CW-1:0]                 count_next;
  logic [N-1:0][PHYS_REGS-1:0]   sel_onehots;
  logic [N-1:0][TW-1:0]          sel_tags;
  logic [N-1:0]                  sel_found;
  logic                          prefix;
  logic [PHYS_REGS-1:0]          granted_mask;
  logic [CW-1:0]                 num_granted;
  logic [PHYS_REGS-1:0]          free_eff;
  logic [PHYS_REGS-1:0]          restore_eff;
  logic [CW:0]                   count_sum;

  function automatic logic [CW-1:0] popcount(input logic [PHYS_REGS-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < PHYS_REGS; i++) c = c + CW'(v[i]);
    return c;
  endfunction

  freelist_psel #(.N(N), .PHYS_REGS(PHYS_REGS)) u_psel (
    .vec     (avail),
    .onehots (sel_onehots),
    .tags    (sel_tags),
    .found   (sel_found)
  );

  // A request hole or exhausted free count kills every younger lane.
  always_comb begin
    prefix       = !reset && !restore_en;
    alloc_grant  = '0;
    alloc_tags   = '0;
    granted_mask = '0;
    num_granted  = '0;
    for (int w = 0; w < N; w++) begin
      prefix = prefix && alloc_req[w] && sel_found[w] && (CW'(w) < free_count);
      alloc_grant[w] = prefix;
      if (prefix) begin
        alloc_tags[w*TW +: TW] = sel_tags[w];
        granted_mask           = granted_mask | sel_onehots[w];
        num_granted            = num_granted + CW'(1);
      end
    end
  end

  assign free_eff    = free_mask & ~PR0_MASK;
  assign restore_eff = restore_mask & ~PR0_MASK;
  assign count_sum   = {1'b0, free_count} + {1'b0, popcount(free_eff & ~avail)}
                     - {1'b0, num_granted};

  always_comb begin
    avail_next = (avail & ~granted_mask) | free_eff;
    count_next = count_sum[CW-1:0];
    if (restore_en) begin
      avail_next = restore_eff;
      count_next = popcount(restore_eff);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      avail      <= INIT_MASK;
      free_count <= CW'(PHYS_REGS - ARCH_COUNT);
    end else begin
      avail      <= avail_next;
      free_count <= count_next;
    end
  end

  assign avail_dbg = avail;

  a_double_free: assert property (@(posedge clock) disable iff (reset)
    !restore_en |-> ((free_eff & avail) == '0));

  a_free_granted: assert property (@(posedge clock) disable iff (reset)
    !restore_en |-> ((free_eff & granted_mask) == '0));

  a_restore_count: assert property (@(posedge clock) disable iff (reset)
    restore_en |-> (popcount(restore_eff) <= CW'(PHYS_REGS - ARCH_COUNT)));

  a_count_range: assert property (@(posedge clock) disable iff (reset)
    !restore_en |-> (count_sum <= (CW+1)'(PHYS_REGS - 1)));

endmodule

// File: tb/tb_phys_freelist.sv
// Directed bench for phys_freelist; the driver queues hand-computed expectations
// and a negedge monitor pops and compares them against the DUT.
module tb_phys_freelist;
  import phys_freelist_pkg::*;

  localparam int N  = 3;
  localparam int PR = 64;
  localparam int AC = 32;
  localparam int CW = 7;
  localparam int TW = 6;

  typedef struct {
    logic [N-1:0]    grant;
    logic [N*TW-1:0] tags;
    logic [CW-1:0]   count;
    logic [PR-1:0]   avail;
  } exp_t;

  logic            clock;
  logic            reset;
  logic [N-1:0]    alloc_req;
  logic [N-1:0]    alloc_grant;
  logic [N*TW-1:0] alloc_tags;
  logic [PR-1:0]   free_mask;
  logic            restore_en;
  logic [PR-1:0]   restore_mask;
  logic [CW-1:0]   free_count;
  logic [PR-1:0]   avail_dbg;

  exp_t scoreboard[$];
  int   errorCount = 0;
  int   checkCount = 0;

  logic [PR-1:0] allOnes;
  logic [PR-1:0] restoreVal;

  phys_freelist #(.N(N), .PHYS_REGS(PR), .ARCH_COUNT(AC)) dut (
    .clock        (clock),
    .reset        (reset),
    .alloc_req    (alloc_req),
    .alloc_grant  (alloc_grant),
    .alloc_tags   (alloc_tags),
    .free_mask    (free_mask),
    .restore_en   (restore_en),
    .restore_mask (restore_mask),
    .free_count   (free_count),
    .avail_dbg    (avail_dbg)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string name, input logic [PR-1:0] actual,
                             input logic [PR-1:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] req, input logic [PR-1:0] fmask,
                               input logic ren, input logic [PR-1:0] rmask,
                               input logic [N-1:0] expGrant, input logic [TW-1:0] t0,
                               input logic [TW-1:0] t1, input logic [TW-1:0] t2,
                               input logic [CW-1:0] expCount, input logic [PR-1:0] expAvail);
    exp_t e;
    @(posedge clock);
    #1;
    alloc_req    = req;
    free_mask    = fmask;
    restore_en   = ren;
    restore_mask = rmask;
    e.grant = expGrant;
    e.tags  = {t2, t1, t0};
    e.count = expCount;
    e.avail = expAvail;
    scoreboard.push_back(e);
  endtask

  always @(negedge clock) begin
    exp_t expd;
    if (scoreboard.size() > 0) begin
      expd = scoreboard.pop_front();
      checkOutput("grant", PR'(alloc_grant), PR'(expd.grant));
      checkOutput("tags",  PR'(alloc_tags),  PR'(expd.tags));
      checkOutput("free_count", PR'(free_count), PR'(expd.count));
      checkOutput("avail", avail_dbg, expd.avail);
    end
  end

  initial begin
    allOnes      = '1;
    restoreVal   = INITIAL_AVAIL_MASK & ~(64'd1 << 36);
    reset        = 1'b0;
    alloc_req    = '0;
    free_mask    = '0;
    restore_en   = 1'b0;
    restore_mask = '0;

    // Reset lands mid-cycle and must take effect without waiting for a clock edge.
    #3;
    reset     = 1'b1;
    alloc_req = 3'b111;
    #1;
    checkOutput("reset_avail", avail_dbg, 64'hFFFF_FFFF_0000_0000);
    checkOutput("reset_count", PR'(free_count), PR'(32));
    checkOutput("reset_grant", PR'(alloc_grant), '0);
    checkOutput("reset_tags",  PR'(alloc_tags), '0);
    #8;
    alloc_req = '0;
    reset     = 1'b0;

    applyStimulus(3'b111, '0, 1'b0, '0, 3'b111, 6'd32, 6'd33, 6'd34, 7'd32, INITIAL_AVAIL_MASK);
    applyStimulus(3'b101, '0, 1'b0, '0, 3'b001, 6'd35, 6'd0, 6'd0, 7'd29, allOnes << 35);
    for (int i = 0; i < 8; i++)
      applyStimulus(3'b111, '0, 1'b0, '0, 3'b111, 6'(36 + 3*i), 6'(37 + 3*i), 6'(38 + 3*i),
                    7'(28 - 3*i), allOnes << (36 + 3*i));
    applyStimulus(3'b011, '0, 1'b0, '0, 3'b011, 6'd60, 6'd61, 6'd0, 7'd4, allOnes << 60);
    applyStimulus(3'b111, '0, 1'b0, '0, 3'b011, 6'd62, 6'd63, 6'd0, 7'd2, allOnes << 62);
    applyStimulus(3'b001, '0, 1'b0, '0, 3'b000, 6'd0, 6'd0, 6'd0, 7'd0, '0);
    applyStimulus(3'b001, 64'd1 << 33, 1'b0, '0, 3'b000, 6'd0, 6'd0, 6'd0, 7'd0, '0);
    applyStimulus(3'b001, '0, 1'b0, '0, 3'b001, 6'd33, 6'd0, 6'd0, 7'd1, 64'd1 << 33);
    applyStimulus(3'b000, allOnes << 41, 1'b0, '0, 3'b000, 6'd0, 6'd0, 6'd0, 7'd0, '0);
    applyStimulus(3'b111, '0, 1'b1, restoreVal | 64'd1, 3'b000, 6'd0, 6'd0, 6'd0,
                  7'd23, allOnes << 41);
    applyStimulus(3'b000, 64'd1, 1'b0, '0, 3'b000, 6'd0, 6'd0, 6'd0, 7'd31, restoreVal);
    applyStimulus(3'b111, '0, 1'b0, '0, 3'b111, 6'd32, 6'd33, 6'd34, 7'd31, restoreVal);
    applyStimulus(3'b111, '0, 1'b0, '0, 3'b111, 6'd35, 6'd37, 6'd38, 7'd28,
                  restoreVal & ~(64'h7 << 32));
    applyStimulus(3'b000, '0, 1'b0, '0, 3'b000, 6'd0, 6'd0, 6'd0, 7'd25,
                  restoreVal & ~(64'hF << 32) & ~(64'h3 << 37));

    @(posedge clock);
    #1;
    alloc_req = '0;
    free_mask = '0;
    for (int i = 0; i < 5; i++) begin
      if (scoreboard.size() == 0) break;
      @(negedge clock);
      #1;
    end
    checkOutput("scoreboard_drained", PR'(scoreboard.size()), '0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
